// File: rtl/sparc_register_file.sv
// sparc_register_file
//   32 x 32-bit general-purpose register file for the SPARC datapath.
//   r0 is hardwired to zero: writes to it are dropped and reads of it return 0.
//   Three independent combinational read ports. One synchronous write port.
//   Reads have no bypass: a register being written shows its old value until
//   the rising edge, and the new value immediately after it.
//
// Ports
//   Clk    in   1           clock; writes occur on the rising edge
//   Reset  in   1           asynchronous active-high reset (clears r1..r31)
//   PA     out  DATA_WIDTH  read data for register RA
//   PB     out  DATA_WIDTH  read data for register RB
//   PD     out  DATA_WIDTH  read data for register RD (store data)
//   PW     in   DATA_WIDTH  write data
//   RW     in   ADDR_WIDTH  write register address
//   RA     in   ADDR_WIDTH  read address, port A
//   RB     in   ADDR_WIDTH  read address, port B
//   RD     in   ADDR_WIDTH  read address, port D
//   LE     in   1           load enable (active-high write enable)

module sparc_register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic [DATA_WIDTH-1:0] PA,
  output logic [DATA_WIDTH-1:0] PB,
  output logic [DATA_WIDTH-1:0] PD,
  input  logic [DATA_WIDTH-1:0] PW,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RD,
  input  logic                  LE
);

  // Only r1..r(NUM_REGS-1) have storage; r0 is a constant zero.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   we_dec;

  // Write address decoder gated by LE. Bit 0 is never used, so r0 writes vanish.
  always_comb begin
    we_dec = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (LE && (RW == ADDR_WIDTH'(i))) begin
        we_dec[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = we_dec[i] ? PW : regs_q[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // 32:1 read mux; address 0 falls through to the zero default.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        val = regs_q[i];
      end
    end
    return val;
  endfunction

  always_comb begin
    PA = read_reg(RA);
    PB = read_reg(RB);
    PD = read_reg(RD);
  end

endmodule

// File: tb/tb_sparc_register_file.sv
module tb_sparc_register_file;

  logic        Clk;
  logic        Reset;
  logic [31:0] PA, PB, PD, PW;
  logic [4:0]  RW, RA, RB, RD;
  logic        LE;

  int tests_run;
  int tests_failed;

  sparc_register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .NUM_REGS   (32)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .PA    (PA),
    .PB    (PB),
    .PD    (PD),
    .PW    (PW),
    .RW    (RW),
    .RA    (RA),
    .RB    (RB),
    .RD    (RD),
    .LE    (LE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        le;
    logic [4:0]  rw;
    logic [31:0] pw;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] exp_pa;
    logic [31:0] exp_pb;
    logic [31:0] exp_pd;
  } vec_t;

  vec_t vecs [35];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, clock it in, sample 1 time unit after the rising edge.
  task automatic apply(input logic le, input logic [4:0] rw, input logic [31:0] pw,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
    @(negedge Clk);
    LE = le; RW = rw; PW = pw; RA = ra; RB = rb; RD = rd;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset = 1'b0;
    LE = 1'b0; RW = '0; PW = '0; RA = 5'd1; RB = 5'd2; RD = 5'd31;

    // Vector table: r0 protection, sequential fill, write disable, r0 with all-ones.
    vecs[0] = '{1'b1, 5'd0, 32'd20, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 1; i <= 31; i++) begin
      int j;
      j = (i - 2) & 31;
      vecs[i].le     = 1'b1;
      vecs[i].rw     = 5'(i);
      vecs[i].pw     = 32'(20 + i);
      vecs[i].ra     = 5'(i);
      vecs[i].rb     = 5'((i - 1) & 31);
      vecs[i].rd     = 5'(j);
      vecs[i].exp_pa = 32'(20 + i);
      vecs[i].exp_pb = (i == 1) ? 32'd0 : 32'(20 + i - 1);
      vecs[i].exp_pd = (j != 0 && j < i) ? 32'(20 + j) : 32'd0;
    end
    vecs[32] = '{1'b1, 5'd5, 32'd55, 5'd5, 5'd4, 5'd6, 32'd55, 32'd24, 32'd26};
    vecs[33] = '{1'b0, 5'd5, 32'd99, 5'd5, 5'd0, 5'd31, 32'd55, 32'd0, 32'd51};
    vecs[34] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd31, 5'd1, 32'd0, 32'd51, 32'd21};

    // Reset asserted mid-cycle: outputs are zero with no clock edge.
    #2 Reset = 1'b1;
    #1;
    check("reset_pa", PA, 32'd0);
    check("reset_pb", PB, 32'd0);
    check("reset_pd", PD, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int k = 0; k < 35; k++) begin
      apply(vecs[k].le, vecs[k].rw, vecs[k].pw, vecs[k].ra, vecs[k].rb, vecs[k].rd);
      check($sformatf("vec%0d_pa", k), PA, vecs[k].exp_pa);
      check($sformatf("vec%0d_pb", k), PB, vecs[k].exp_pb);
      check($sformatf("vec%0d_pd", k), PD, vecs[k].exp_pd);
    end

    // Read-during-write: old value before the edge, new value right after.
    apply(1'b1, 5'd7, 32'd10, 5'd7, 5'd0, 5'd0);
    check("rdw_setup", PA, 32'd10);
    @(negedge Clk);
    LE = 1'b1; RW = 5'd7; PW = 32'd77; RA = 5'd7;
    #1;
    check("rdw_before", PA, 32'd10);
    @(posedge Clk);
    #1;
    check("rdw_after", PA, 32'd77);

    // Inputs wiggled between edges have no effect; only the edge value counts.
    @(negedge Clk);
    LE = 1'b1; RW = 5'd9; PW = 32'd500; RA = 5'd9;
    #2 PW = 32'd600;
    #1 LE = 1'b0;
    @(posedge Clk);
    #1;
    check("between_edges", PA, 32'd29);

    // Async reset mid-operation, then a write attempted while reset is held.
    apply(1'b1, 5'd3, 32'd42, 5'd3, 5'd7, 5'd5);
    check("r3_written", PA, 32'd42);
    check("r7_before_rst", PB, 32'd77);
    @(negedge Clk);
    LE = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("midop_rst_pa", PA, 32'd0);
    check("midop_rst_pb", PB, 32'd0);
    check("midop_rst_pd", PD, 32'd0);
    LE = 1'b1; RW = 5'd3; PW = 32'd123;
    @(posedge Clk);
    #1;
    check("write_in_rst", PA, 32'd0);
    @(negedge Clk);
    LE = 1'b0;
    Reset = 1'b0;
    #1;
    check("after_rst_r3", PA, 32'd0);
    apply(1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd3, 5'd0);
    check("post_rst_wr", PA, 32'hDEAD_BEEF);
    check("post_rst_r3", PB, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Overall watchdog so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
